sq_voice_controller: RTL
========================

# sq_voice_controller

Sequencing controller for the square-wave voice. It owns the phase accumulator that drives `sq_wave_generator`'s 8-bit `period` (phase) input and accepts note-on/note-off commands over a valid/ready handshake. It applies a linear attack/release amplitude ramp to the generator's 11-bit `square` output. It sits between the note/MIDI front end and the audio mixer, and advances once per sample strobe.

## Interface
- `PHASE_W`, 24: phase accumulator width; top 8 bits drive `period`. Must be at least 8.
- `RAMP_STEP`, 16: amplitude change per sample tick during attack/release; range 1..255.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sample_tick`  in  1  one-cycle strobe at the audio sample rate.
- `note_valid`  in  1  command valid.
- `note_ready`  out  1  command accept; a transfer occurs when `note_valid & note_ready`.
- `note_on`  in  1  1 = note-on, 0 = note-off (sampled with `note_valid`).
- `note_inc`  in  PHASE_W  phase increment per tick (tuning word); used on note-on only.
- `period`  out  8  phase to `sq_wave_generator` = `phase[PHASE_W-1:PHASE_W-8]`.
- `square`  in  11  unsigned sample returned by `sq_wave_generator` (combinational from `period`).
- `sample_out`  out  11  amplitude-scaled sample.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `state`  out  2  0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE.

## Operation
- Registers: `phase` (PHASE_W), `inc` (PHASE_W), `amp` (8), `state` (2), `sample_out`, `sample_valid`.
- `note_ready = rst_n & ~sample_tick` (combinational). Commands are stalled only in tick cycles, so a command and a tick are never processed in the same cycle.
- Accepted note-on:
  - `inc <= note_inc` in all states.
  - IDLE: `phase <= 0`, `amp <= 0`, go to ATTACK.
  - ATTACK or SUSTAIN: retune only; `phase`, `amp` and state are unchanged.
  - RELEASE: go to ATTACK, keeping the current `amp` and `phase` (legato retrigger).
- Accepted note-off: ATTACK or SUSTAIN go to RELEASE. In IDLE or RELEASE it is ignored (no state or register change).
- On `sample_tick`, with state not IDLE:
  - `phase <= phase + inc`, wrapping modulo 2^PHASE_W.
  - ATTACK: `amp <= min(amp + RAMP_STEP, 255)`. When the new value is 255, go to SUSTAIN.
  - SUSTAIN: `amp` is held.
  - RELEASE: `amp <= max(amp - RAMP_STEP, 0)`. When the new value is 0, go to IDLE and set `phase <= 0`.
- On `sample_tick` in IDLE: `phase` and `amp` are held.
- Output scaling:
  - `sample_out <= (square * amp) >> 8`, using 19-bit intermediate product and keeping the low 11 bits of the shifted result.
  - Uses the `square` and `amp` values present in the tick cycle, i.e. the pre-update phase and amplitude.
  - In IDLE the result is 0 because `amp` is 0.
- `sample_valid` pulses on every tick, including in IDLE.

## Timing
- Reset (`rst_n = 0` at a clock edge), regardless of current state:
  - `phase`, `inc`, `amp`, `sample_out` all 0; `state` IDLE.
  - Outputs therefore read `period` = 0, `sample_valid` = 0, `state` = 0.
  - `note_ready` is 0 while `rst_n` is low.
- Command latency: state, `inc` and `phase` change at the edge that accepts the command; the new `state` is visible the next cycle.
- Tick latency:
  - `sample_out` and `sample_valid` are updated at the tick edge and visible the cycle after the tick, for exactly one cycle of `sample_valid`.
  - `period` reflects the advanced phase in that same cycle.
- Back-to-back ticks on consecutive cycles are legal; each advances phase and ramp once.
- `note_valid` held high across a tick cycle is accepted on the first non-tick cycle. Upstream must hold `note_valid`/`note_on`/`note_inc` stable until accepted.
- Ramp durations with RAMP_STEP = 16:
  - Attack from 0 reaches 255 (SUSTAIN) on the 16th tick: 16, 32, …, 240, 255.
  - Release from 255 reaches 0 (IDLE) on the 16th tick: 239, …, 15, 0.

## Test plan
- Reset mid-ATTACK, at amp = 80: assert `rst_n = 0` for one edge -> `state` = 0, `period` = 0, `sample_out` = 0, `note_ready` = 0 during reset and 1 after.
- Note-on with `note_inc = 24'h010000`, then 20 ticks, `square` from the real `sq_wave_generator`:
  - `period` steps 1, 2, … one per tick.
  - `amp` reaches 255 and `state` = 2 exactly after tick 16.
  - `sample_out` equals `(square*amp)>>8` one cycle after each tick.
- Note-off in SUSTAIN, then 16 ticks -> `state` = 3 until tick 16, then 0; `period` = 0; subsequent ticks give `sample_out` = 0 with `sample_valid` still pulsing.
- Wrap-around with `note_inc = 24'hC00000` -> `period` sequence 0, 192, 128, 64, 0 with no glitch at wrap.
- Note-on during RELEASE at amp = 143 -> `state` = 1 and the next tick gives amp 159 (no reset to 0, phase continues).
- `note_valid` asserted in a `sample_tick` cycle -> `note_ready` = 0 and no acceptance that cycle; accepted the following non-tick cycle. A note-off while IDLE -> no change.

Source files
------------

// File: rtl/sq_voice_controller.sv
// sq_voice_controller: phase accumulator and linear
// attack/release envelope for the square-wave voice
module sq_voice_controller #(
  parameter int PHASE_W   = 24,
  parameter int RAMP_STEP = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic               note_on,
  input  logic [PHASE_W-1:0] note_inc,
  output logic [7:0]         period,
  input  logic [10:0]        square,
  output logic [10:0]        sample_out,
  output logic               sample_valid,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } st_t;

  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  st_t                st;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc;
  logic [7:0]         amp;
  logic [8:0]         amp_up;
  logic [7:0]         amp_dn;
  logic               amp_top;
  logic               amp_zero;
  logic [10:0]        scaled;
  logic               take;

  assign note_ready = rst_n & ~sample_tick;
  assign take       = note_valid & note_ready;
  assign period     = phase[PHASE_W-1 -: 8];
  assign state      = st;

  // saturating ramp steps and amplitude scaling
  always_comb begin
    amp_up   = {1'b0, amp} + STEP9;
    amp_top  = amp_up >= 9'd255;
    amp_zero = {1'b0, amp} <= STEP9;
    amp_dn   = amp - STEP9[7:0];
    scaled   = 11'(({8'b0, square} * {11'b0, amp}) >> 8);
  end

  // ticks advance phase/envelope; commands only land off-tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= IDLE;
      phase        <= '0;
      inc          <= '0;
      amp          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_tick;
      if (sample_tick) begin
        sample_out <= scaled;
        if (st != IDLE) phase <= phase + inc;
        unique case (st)
          ATTACK: begin
            if (amp_top) begin
              amp <= 8'hFF;
              st  <= SUSTAIN;
            end else begin
              amp <= amp_up[7:0];
            end
          end
          RELEASE: begin
            if (amp_zero) begin
              amp   <= '0;
              st    <= IDLE;
              phase <= '0;
            end else begin
              amp <= amp_dn;
            end
          end
          default: ;
        endcase
      end else if (take) begin
        if (note_on) begin
          inc <= note_inc;
          if (st == IDLE) begin
            phase <= '0;
            amp   <= '0;
            st    <= ATTACK;
          end else if (st == RELEASE) begin
            st <= ATTACK;
          end
        end else if (st == ATTACK || st == SUSTAIN) begin
          st <= RELEASE;
        end
      end
    end
  end

endmodule
